hilo_register_unit: RTL

- Parametrised HI/LO special-register unit in the writeback stage.
- Holds the HI and LO halves of the multiply/divide result.
- Supports direct writes (MTHI/MTLO, MULT/DIV results) and two-cycle multiply-accumulate commits (MADD/MSUB), with optional signed saturation.
- An accept/ready handshake and a flush input let the pipeline cancel an in-flight accumulate on an exception.

---
 rtl/hilo_register_unit_pkg.sv | 28 ++
 rtl/hilo_register_unit_if.sv | 21 ++
 rtl/hilo_register_unit_accumulate_alu.sv | 38 +++
 rtl/hilo_register_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/hilo_register_unit_pkg.sv
// Shared op_code encodings, FSM state type and reset polarity for the HI/LO register unit.
`ifndef HILO_REGISTER_UNIT_PKG_SV
`define HILO_REGISTER_UNIT_PKG_SV
`define RESET_ENABLE 1'b1

package hilo_register_unit_pkg;

  typedef enum logic [2:0] {
    HILO_OP_NONE       = 3'd0,
    HILO_OP_WRITE_HI   = 3'd1,
    HILO_OP_WRITE_LO   = 3'd2,
    HILO_OP_WRITE_BOTH = 3'd3,
    HILO_OP_MADD       = 3'd4,
    HILO_OP_MSUB       = 3'd5
  } hilo_op_e;

  typedef enum logic {
    HILO_IDLE    = 1'b0,
    HILO_PENDING = 1'b1
  } hilo_state_e;

  function automatic logic is_accumulate(input logic [2:0] code);
    return (code == HILO_OP_MADD) || (code == HILO_OP_MSUB);
  endfunction

endpackage

`endif

// File: rtl/hilo_register_unit_if.sv
// Operation request bus into the HI/LO register unit.
interface hilo_register_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_hi_data;
  logic [WIDTH-1:0] op_lo_data;
  logic             flush;

  modport master (
    output op_valid, op_code, op_hi_data, op_lo_data, flush,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_code, op_hi_data, op_lo_data, flush,
    output op_ready
  );
endinterface

// File: rtl/hilo_register_unit_accumulate_alu.sv
// Combinational {HI,LO} +/- operand with optional signed saturation of the 2*WIDTH result.
module hilo_accumulate_alu #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic signed [2*WIDTH-1:0] acc,
  input  logic signed [2*WIDTH-1:0] operand,
  input  logic                      subtract,
  output logic        [2*WIDTH-1:0] result,
  output logic                      saturated
);
  localparam int AW = 2 * WIDTH;

  logic signed [AW:0] acc_ext;
  logic signed [AW:0] opd_ext;
  logic signed [AW:0] sum_ext;
  logic               overflow;

  // The extra bit disagrees with the result sign exactly on signed overflow.
  function automatic logic [AW-1:0] clamp(input logic signed [AW:0] v, input logic ovf);
    logic [AW-1:0] r;
    r = v[AW-1:0];
    if (SATURATE && ovf) begin
      r = {AW{~v[AW]}};
      r[AW-1] = v[AW];
    end
    return r;
  endfunction

  always_comb begin
    acc_ext   = {acc[AW-1], acc};
    opd_ext   = {operand[AW-1], operand};
    sum_ext   = subtract ? (acc_ext - opd_ext) : (acc_ext + opd_ext);
    overflow  = sum_ext[AW] ^ sum_ext[AW-1];
    result    = clamp(sum_ext, overflow);
    saturated = SATURATE && overflow;
  end
endmodule

// File: rtl/hilo_register_unit.sv
// HI/LO special-register unit: direct writes commit on acceptance, MADD/MSUB commit one edge later.
module hilo_register_unit
  import hilo_register_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  hilo_register_unit_if.slave  bus,
  output logic [WIDTH-1:0]     hi_read_data,
  output logic [WIDTH-1:0]     lo_read_data,
  output logic                 busy,
  output logic                 saturated,
  input  logic                 clear_saturated
);
  hilo_state_e            state_p0;
  hilo_state_e            state_next;
  logic [WIDTH-1:0]       hi_p1;
  logic [WIDTH-1:0]       lo_p1;
  logic [2*WIDTH-1:0]     operand_p0;
  logic                   sub_p0;
  logic                   sat_flag;

  logic                   ready;
  logic                   accept;
  logic                   wr_hi;
  logic                   wr_lo;
  logic                   start_acc;
  logic                   commit;
  logic [2*WIDTH-1:0]     alu_result;
  logic                   alu_sat;

  hilo_accumulate_alu #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .acc       ({hi_p1, lo_p1}),
    .operand   (operand_p0),
    .subtract  (sub_p0),
    .result    (alu_result),
    .saturated (alu_sat)
  );

  always_comb begin
    ready      = (state_p0 == HILO_IDLE) && !bus.flush;
    accept     = bus.op_valid && ready &&
                 (bus.op_code != HILO_OP_NONE) && (bus.op_code <= HILO_OP_MSUB);
    wr_hi      = accept && ((bus.op_code == HILO_OP_WRITE_HI) || (bus.op_code == HILO_OP_WRITE_BOTH));
    wr_lo      = accept && ((bus.op_code == HILO_OP_WRITE_LO) || (bus.op_code == HILO_OP_WRITE_BOTH));
    start_acc  = accept && is_accumulate(bus.op_code);
    commit     = (state_p0 == HILO_PENDING) && !bus.flush;
    state_next = state_p0;
    case (state_p0)
      HILO_IDLE:    if (start_acc) state_next = HILO_PENDING;
      HILO_PENDING: state_next = HILO_IDLE;
      default:      state_next = HILO_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset == `RESET_ENABLE) begin
      state_p0 <= HILO_IDLE;
    end else begin
      state_p0 <= state_next;
    end
  end

  // Stage p0: pending accumulate operand; stage p1: architectural HI/LO.
  always_ff @(posedge clock) begin
    if (reset == `RESET_ENABLE) begin
      hi_p1      <= '0;
      lo_p1      <= '0;
      operand_p0 <= '0;
      sub_p0     <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (commit) begin
        {hi_p1, lo_p1} <= alu_result;
      end else begin
        if (wr_hi) hi_p1 <= bus.op_hi_data;
        if (wr_lo) lo_p1 <= bus.op_lo_data;
      end
      if (start_acc) begin
        operand_p0 <= {bus.op_hi_data, bus.op_lo_data};
        sub_p0     <= (bus.op_code == HILO_OP_MSUB);
      end
      if (commit && alu_sat)  sat_flag <= 1'b1;
      else if (clear_saturated) sat_flag <= 1'b0;
    end
  end

  assign bus.op_ready  = ready;
  assign hi_read_data  = hi_p1;
  assign lo_read_data  = lo_p1;
  assign busy          = (state_p0 == HILO_PENDING);
  assign saturated     = sat_flag;
endmodule
